// File: rtl/music_box_pkg.sv
// Shared constants and types for the music box blocks.
//   NUM_KEYS        number of music keys on the gated key bus
//   KEY_W           width of a key index
//   key_idx_t       key index 0..NUM_KEYS-1
//   STATE_IDLE/STATE_PLAYBACK  state-controller codes in which voices may sound
package music_box_pkg;

  localparam int unsigned NUM_KEYS = 6;
  localparam int unsigned KEY_W    = 3;

  typedef logic [KEY_W-1:0] key_idx_t;

  localparam logic [4:0] STATE_IDLE     = 5'd0;
  localparam logic [4:0] STATE_PLAYBACK = 5'd4;

endpackage : music_box_pkg

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a run-length debouncer for one key.
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   key_i     raw key level, asynchronous to clk_i
//   stable_o  debounced key level (registered)
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic stable_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the synced level only after it has disagreed for DEBOUNCE_CYCLES edges.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], key_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule : key_debouncer

// File: rtl/music_voice_allocator.sv
// Debounces the six gated music keys and assigns each held key to a voice.
// Allocation: lowest pending key to lowest free voice, one per cycle, no stealing.
//   clock_50Mhz    system clock
//   reset_n        asynchronous active-low reset
//   allocEnable    high while the box is in a play-capable state; low flushes voices
//   keyPressed     gated key-held bits (asynchronous)
//   voiceActive    voice v is sounding
//   voiceKey       key index per voice, 3 bits each, valid while voiceActive[v]
//   voiceStart     one-cycle pulse when voiceActive[v] rises
//   voiceOverflow  a debounced-held key is waiting and every voice is busy
//   debugString    [5:0] debounced keys, [11:6] assigned mask, [15:12] busy count;
//                  registered snapshot of the state at the start of the previous cycle
module music_voice_allocator
  import music_box_pkg::*;
#(
  parameter int unsigned NUM_VOICES      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                        clock_50Mhz,
  input  logic                        reset_n,
  input  logic                        allocEnable,
  input  logic [NUM_KEYS-1:0]         keyPressed,
  output logic [NUM_VOICES-1:0]       voiceActive,
  output logic [NUM_VOICES*KEY_W-1:0] voiceKey,
  output logic [NUM_VOICES-1:0]       voiceStart,
  output logic                        voiceOverflow,
  output logic [31:0]                 debugString
);

  logic [NUM_KEYS-1:0]   stable;
  logic [NUM_KEYS-1:0]   assigned, pending;
  logic [NUM_VOICES-1:0] free, grant;
  logic [3:0]            busy;
  key_idx_t              key_sel;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] start_q, start_d;
  key_idx_t              key_q [NUM_VOICES];
  key_idx_t              key_d [NUM_VOICES];
  logic                  ovf_q, ovf_d;
  logic [31:0]           debug_q, debug_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (clock_50Mhz),
      .rst_ni  (reset_n),
      .key_i   (keyPressed[k]),
      .stable_o(stable[k])
    );
  end

  // Keys already owned by a voice, and the number of busy voices.
  always_comb begin
    assigned = '0;
    busy     = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (active_q[v]) begin
        assigned[key_q[v]] = 1'b1;
        busy = busy + 4'd1;
      end
    end
  end

  assign pending = stable & ~assigned & {NUM_KEYS{allocEnable}};
  assign free    = ~active_q;
  // Isolate the lowest set bit of the free mask.
  assign grant   = free & (~free + NUM_VOICES'(1));

  // Lowest-index pending key.
  always_comb begin
    key_sel = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending[k]) begin
        key_sel = key_idx_t'(k);
      end
    end
  end

  // Voice table update: flush, release, then at most one allocation.
  always_comb begin
    active_d = active_q;
    key_d    = key_q;
    start_d  = '0;
    ovf_d    = (|pending) && (free == '0);
    debug_d  = {16'b0, busy, assigned, stable};
    if (!allocEnable) begin
      active_d = '0;
    end else begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        if (active_q[v] && !stable[key_q[v]]) begin
          active_d[v] = 1'b0;
        end
      end
      if (|pending) begin
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
          if (grant[v]) begin
            active_d[v] = 1'b1;
            key_d[v]    = key_sel;
            start_d[v]  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      start_q  <= '0;
      key_q    <= '{default: '0};
      ovf_q    <= 1'b0;
      debug_q  <= '0;
    end else begin
      active_q <= active_d;
      start_q  <= start_d;
      key_q    <= key_d;
      ovf_q    <= ovf_d;
      debug_q  <= debug_d;
    end
  end

  always_comb begin
    voiceKey = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      voiceKey[v*KEY_W +: KEY_W] = key_q[v];
    end
  end

  assign voiceActive   = active_q;
  assign voiceStart    = start_q;
  assign voiceOverflow = ovf_q;
  assign debugString   = debug_q;

endmodule : music_voice_allocator

// File: doc/music_voice_allocator.md
# music_voice_allocator

Debounces the six gated music-key signals and assigns each held key to one of a small pool of tone-generator voices. It sits between the music keys controller (gated `outputKeyPressed` bus) and the frequency generator, so that several simultaneous keys share a limited number of synthesis channels. Allocation is deterministic (lowest key first, lowest free voice first, no voice stealing), and all voices are flushed when the box leaves a play-capable state.

## Interface
Parameters:
- NUM_VOICES, 3: number of tone-generator voices, 1..6.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles before a key change is accepted (5 ms at 50 MHz), ≥2.

Ports:
- clock_50Mhz  in  1  system clock. One clock only.
- reset_n  in  1  reset, asynchronous, active-low.
- allocEnable  in  1  high while currentState is 0 or 4. Low flushes all voices.
- keyPressed  in  6  gated key-held bits, active-high, asynchronous to the clock.
- voiceActive  out  NUM_VOICES  voice v is sounding.
- voiceKey  out  NUM_VOICES×3  key index 0..5 driven to voice v; valid while voiceActive[v].
- voiceStart  out  NUM_VOICES  one-cycle pulse on the cycle voiceActive[v] rises.
- voiceOverflow  out  1  a debounced-held key has no voice.
- debugString  out  32  [5:0] debounced keys, [11:6] assigned-key mask, [15:12] busy-voice count, rest 0.

## Operation
- Per key: two-flop synchronizer, then debouncer.
  - The debouncer counter increments while the synced value ≠ stable value.
  - It clears when the values match.
  - When counter = DEBOUNCE_CYCLES−1 and the mismatch persists, stable ← synced and counter ← 0.
- Pending set: keys with stable = 1, not assigned, and allocEnable = 1.
- Allocation: at most one per cycle.
  - Choose the lowest-index pending key and the lowest-index free voice, both taken from the registered state at the start of the cycle.
  - Set voiceActive[v], voiceKey[v], and a one-cycle voiceStart[v].
- Release: when a key's stable value falls, the voice holding it clears voiceActive on the next edge. voiceKey holds its last value.
- Release and allocation in the same cycle both take effect. The freed voice is not reusable until the following cycle.
- Pending key released before allocation: dropped, no output activity.
- All voices busy: no stealing. voiceOverflow = 1 while the pending set is non-empty and no voice is free (registered).
- allocEnable low: all voiceActive clear on the next edge, no voiceStart. Debouncers keep running.
- allocEnable rising: keys still held re-allocate, one per cycle.
- A key is never assigned to two voices.

## Timing
- Reset values: voiceActive 0, voiceKey 0, voiceStart 0, voiceOverflow 0, debugString 0, synchronizers 0, debounce stable 0, counters 0.
- Press latency, keyPressed rise to voiceActive/voiceStart: 2 sync + DEBOUNCE_CYCLES + 1 cycles, when a voice is free and no lower key is pending.
- Release latency: 2 + DEBOUNCE_CYCLES + 1 cycles to voiceActive fall.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- N keys stabilising together are allocated on N consecutive cycles, in ascending key order.
- reset_n asserted mid-operation: all state clears immediately (asynchronous). The first allocation is possible only after a full debounce interval following reset release.

## Structure
- Package music_box_pkg:
  - NUM_KEYS = 6
  - typedef logic [2:0] key_idx_t
  - STATE_IDLE = 5'd0, STATE_PLAYBACK = 5'd4, shared with the state controller.
- Sub-module key_debouncer, holding the synchronizer, counter and stable bit, parameterised by DEBOUNCE_CYCLES. Instantiate it NUM_KEYS times.
- The top holds the voice table, the priority encoders, the overflow flag and debugString.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and NUM_VOICES = 3.
- Single press: key 2 held from cycle 0 → voiceActive[0]=1, voiceKey[0]=2, voiceStart[0] pulse at cycle 7. Release at cycle 20 → voiceActive[0]=0 at cycle 27.
- Glitch: key 1 high for 3 cycles → no output change, debugString[5:0] stays 0.
- Simultaneous: keys 5, 0 and 3 pressed together → voices 0/1/2 get keys 0/3/5 on cycles 7/8/9.
- Overflow: keys 0–3 held → voices hold 0, 1, 2 and voiceOverflow=1. Release key 1 → its voice frees, then key 3 takes voice 1 on the following cycle and voiceOverflow=0.
- Flush: 2 voices active, allocEnable low for 5 cycles → all voiceActive=0 next edge. allocEnable high again → keys re-allocate on consecutive cycles with voiceStart pulses.
- Reset mid-allocation: reset_n low while keys are held → all outputs 0 immediately. Re-allocation occurs 7 cycles after release.
